// File: rtl/pwm_tick_generator.sv
// pwm_tick_generator: tick-driven PWM with double-buffered period/duty applied only at period boundaries.
module pwm_tick_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             cycle_start
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_period_q, act_period_d, act_duty_q, act_duty_d;
  logic [WIDTH-1:0] pend_period_q, pend_period_d, pend_duty_q, pend_duty_d;
  logic             pend_valid_q, pend_valid_d, pwm_q, pwm_d, cs_q, cs_d;
  logic             idle, wrap, apply;
  always_comb begin
    idle          = state_q == IDLE;
    wrap          = !idle && enable && tick && cnt_q == act_period_q;
    apply         = pend_valid_q && (idle || wrap);
    act_period_d  = apply ? pend_period_q : act_period_q;
    act_duty_d    = apply ? pend_duty_q : act_duty_q;
    pend_period_d = load ? period : pend_period_q;
    pend_duty_d   = load ? duty : pend_duty_q;
    pend_valid_d  = load || (pend_valid_q && !apply);
    state_d       = enable ? RUN : IDLE;
    cnt_d         = (!enable || idle || wrap) ? '0 : cnt_q + WIDTH'(tick);
    cs_d          = enable && (idle || wrap);
    // Output follows the post-update count against the post-apply duty; otherwise held.
    pwm_d         = !enable ? 1'b0 : (idle || tick) ? (cnt_d < act_duty_d) : pwm_q;
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_valid_q  <= 1'b0;
      pwm_q         <= 1'b0;
      cs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_valid_q  <= pend_valid_d;
      pwm_q         <= pwm_d;
      cs_q          <= cs_d;
    end
  end
  assign pwm_out     = pwm_q;
  assign cycle_start = cs_q;
endmodule

// File: tb/tb_pwm_tick_generator.sv
// tb_pwm_tick_generator: vector table, directed corner sequences and random stimulus vs a position-in-period model.
module tb_pwm_tick_generator;
  logic       clock = 1'b0, rst = 1'b0, tick = 1'b0, enable = 1'b0, load = 1'b0;
  logic [7:0] period = '0, duty = '0;
  logic       pwm_out, cycle_start;
  int         checks = 0, errors = 0;
  always #5 clock = ~clock;
  pwm_tick_generator #(.WIDTH(8)) dut (
    .clock(clock), .rst(rst), .tick(tick), .enable(enable), .load(load),
    .period(period), .duty(duty), .pwm_out(pwm_out), .cycle_start(cycle_start)
  );
  // Model: position within a period of length (period+1); output high while position < duty.
  bit m_run, m_pv, m_pwm, m_cs;
  int m_pos, m_aper, m_aduty, m_pper, m_pduty;
  task automatic m_reset();
    m_run = 0; m_pv = 0; m_pwm = 0; m_cs = 0;
    m_pos = 0; m_aper = 0; m_aduty = 0; m_pper = 0; m_pduty = 0;
  endtask
  task automatic m_step();
    bit boundary = 0;
    if (m_run && enable && tick) begin
      m_pos = (m_pos + 1) % (m_aper + 1);
      boundary = (m_pos == 0);
    end
    if (m_pv && (!m_run || boundary)) begin
      m_aper = m_pper; m_aduty = m_pduty; m_pv = 0;
    end
    if (load) begin
      m_pper = int'(period); m_pduty = int'(duty); m_pv = 1;
    end
    if (!enable) begin
      m_run = 0; m_pos = 0; m_pwm = 0; m_cs = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_cs = 1; m_pwm = m_aduty > 0;
    end else if (tick) begin
      m_cs = boundary; m_pwm = m_pos < m_aduty;
    end else m_cs = 0;
  endtask
  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask
  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_model(input string n);
    chk({n, "_pwm"}, pwm_out, m_pwm);
    chk({n, "_cs"}, cycle_start, m_cs);
  endtask
  task automatic drv(input logic en, input logic tk, input logic ld, input logic [7:0] p, input logic [7:0] d);
    enable = en; tick = tk; load = ld; period = p; duty = d;
  endtask
  task automatic cyc();
    m_step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    drv(0, 0, 0, 0, 0);
    rst = 1'b0;
    m_reset();
    #2;
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_cs", cycle_start, 1'b0);
    rst = 1'b1;
  endtask
  typedef struct {
    logic en, tk, ld;
    logic [7:0] per, du;
    logic pwm, cs;
  } vec_t;
  vec_t v[20];
  function automatic vec_t mk(logic en, logic tk, logic ld, logic [7:0] p, logic [7:0] d, logic pw, logic c);
    vec_t r;
    r.en = en; r.tk = tk; r.ld = ld; r.per = p; r.du = d; r.pwm = pw; r.cs = c;
    return r;
  endfunction
  int hi;
  initial begin
    v[0]  = mk(0, 0, 1, 0, 1, 0, 0);
    v[1]  = mk(1, 0, 0, 0, 0, 1, 1);
    v[2]  = mk(1, 1, 0, 0, 0, 1, 1);
    v[3]  = mk(1, 0, 0, 0, 0, 1, 0);
    v[4]  = mk(1, 1, 0, 0, 0, 1, 1);
    v[5]  = mk(1, 1, 0, 0, 0, 1, 1);
    v[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(0, 0, 1, 4, 9, 0, 0);
    v[8]  = mk(1, 0, 0, 0, 0, 1, 1);
    v[9]  = mk(1, 1, 0, 0, 0, 1, 0);
    v[10] = mk(1, 1, 0, 0, 0, 1, 0);
    v[11] = mk(1, 1, 0, 0, 0, 1, 0);
    v[12] = mk(1, 1, 0, 0, 0, 1, 0);
    v[13] = mk(1, 1, 0, 0, 0, 1, 1);
    v[14] = mk(0, 0, 0, 0, 0, 0, 0);
    v[15] = mk(0, 0, 1, 4, 0, 0, 0);
    v[16] = mk(1, 0, 0, 0, 0, 0, 1);
    v[17] = mk(1, 1, 0, 0, 0, 0, 0);
    v[18] = mk(1, 1, 0, 0, 0, 0, 0);
    v[19] = mk(0, 1, 0, 0, 0, 0, 0);
    #12;
    do_reset();
    foreach (v[i]) begin
      drv(v[i].en, v[i].tk, v[i].ld, v[i].per, v[i].du);
      cyc();
      chk($sformatf("vec%0d_pwm", i), pwm_out, v[i].pwm);
      chk($sformatf("vec%0d_cs", i), cycle_start, v[i].cs);
    end
    // 4/2 with a tick every third clock: 15-clock period, high for the first 6 clocks.
    do_reset();
    drv(0, 0, 1, 4, 2);
    cyc();
    for (int i = 0; i < 45; i++) begin
      drv(1, i > 0 && i % 3 == 0, 0, 4, 2);
      cyc();
      chk($sformatf("t1_pwm%0d", i), pwm_out, i % 15 < 6);
      chk($sformatf("t1_cs%0d", i), cycle_start, i % 15 == 0);
    end
    // Mid-period reload: current 4/2 period completes before 9/5 applies.
    do_reset();
    drv(0, 0, 1, 4, 2); cyc(); chk_model("t3_load");
    drv(1, 0, 0, 0, 0); cyc(); chk_model("t3_enter");
    for (int i = 0; i < 2; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t3_pre"); end
    drv(1, 0, 1, 9, 5); cyc(); chk_model("t3_reload");
    for (int i = 0; i < 3; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t3_finish"); end
    chk("t3_wrap_cs", cycle_start, 1'b1);
    hi = int'(pwm_out);
    for (int i = 0; i < 9; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t3_new"); hi += int'(pwm_out); end
    chki("t3_high", hi, 5);
    // Load on the wrap edge itself while 6/1 is pending.
    drv(1, 0, 1, 6, 1); cyc(); chk_model("t4_pend");
    drv(1, 1, 1, 9, 5); cyc(); chk_model("t4_wrap");
    chk("t4_wrap_cs", cycle_start, 1'b1);
    hi = int'(pwm_out);
    for (int i = 0; i < 6; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t4_61"); hi += int'(pwm_out); end
    chki("t4_high61", hi, 1);
    drv(1, 1, 0, 0, 0); cyc(); chk_model("t4_wrap2");
    chk("t4_wrap2_cs", cycle_start, 1'b1);
    hi = int'(pwm_out);
    for (int i = 0; i < 9; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t4_95"); hi += int'(pwm_out); end
    chki("t4_high95", hi, 5);
    // Drop enable in the high phase, then re-enter.
    for (int i = 0; i < 4; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t5_run"); end
    drv(0, 1, 0, 0, 0); cyc(); chk_model("t5_drop");
    chk("t5_drop_pwm", pwm_out, 1'b0);
    drv(1, 0, 0, 0, 0); cyc(); chk_model("t5_reenter");
    chk("t5_reenter_cs", cycle_start, 1'b1);
    chk("t5_reenter_pwm", pwm_out, 1'b1);
    for (int i = 0; i < 10; i++) begin drv(1, 1, 0, 0, 0); cyc(); chk_model("t5_full"); end
    // Asynchronous reset between edges while the output is high.
    chk("t6_pre_pwm", pwm_out, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_pwm", pwm_out, 1'b0);
    chk("t6_async_cs", cycle_start, 1'b0);
    rst = 1'b1;
    m_reset();
    drv(1, 0, 0, 0, 0); cyc(); chk_model("t6_enter");
    chk("t6_enter_cs", cycle_start, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 0, 0, 0); cyc(); chk_model("t6_run");
      chk("t6_zero_pwm", pwm_out, 1'b0);
    end
    for (int i = 0; i < 600; i++) begin
      drv($urandom % 8 != 0, $urandom % 3 == 0, $urandom % 10 == 0, 8'($urandom % 6), 8'($urandom % 8));
      cyc();
      chk_model("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
